// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 set-2 scan-code decoder: prefix/control bytes,
// the tracked-key table behind the held-key bitmap, and the FSM state encoding.
package ps2_pkg;

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_PAUSE  = 8'hE1;
    localparam logic [7:0] CODE_ACK    = 8'hFA;
    localparam logic [7:0] CODE_BAT_OK = 8'hAA;
    localparam logic [7:0] CODE_ECHO   = 8'hEE;
    localparam logic [7:0] CODE_OVF0   = 8'h00;
    localparam logic [7:0] CODE_OVF1   = 8'hFF;

    // Bytes that follow E1 before the pause event is reported.
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    localparam int NUM_KEYS = 8;

    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam logic [2:0] IDX_W     = 3'd0;
    localparam logic [2:0] IDX_A     = 3'd1;
    localparam logic [2:0] IDX_S     = 3'd2;
    localparam logic [2:0] IDX_D     = 3'd3;
    localparam logic [2:0] IDX_UP    = 3'd4;
    localparam logic [2:0] IDX_DOWN  = 3'd5;
    localparam logic [2:0] IDX_LEFT  = 3'd6;
    localparam logic [2:0] IDX_RIGHT = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
    } key_entry_t;

    function automatic key_entry_t tracked_key(input logic [2:0] idx);
        key_entry_t entry;
        case (idx)
            IDX_W:     entry = '{code: KEY_W,     ext: 1'b0};
            IDX_A:     entry = '{code: KEY_A,     ext: 1'b0};
            IDX_S:     entry = '{code: KEY_S,     ext: 1'b0};
            IDX_D:     entry = '{code: KEY_D,     ext: 1'b0};
            IDX_UP:    entry = '{code: KEY_UP,    ext: 1'b1};
            IDX_DOWN:  entry = '{code: KEY_DOWN,  ext: 1'b1};
            IDX_LEFT:  entry = '{code: KEY_LEFT,  ext: 1'b1};
            default:   entry = '{code: KEY_RIGHT, ext: 1'b1};
        endcase
        return entry;
    endfunction

    // Keyboard housekeeping replies that never form part of a key sequence.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == CODE_ACK) || (code == CODE_BAT_OK) || (code == CODE_ECHO) ||
               (code == CODE_OVF0) || (code == CODE_OVF1);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/ps2_key_map.sv
// Combinational lookup of a (code, ext) pair against the tracked-key table,
// returning whether it hits and which held-key bit it owns.
module ps2_key_map
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic       hit,
    output logic [2:0] index
);

    logic [NUM_KEYS-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_match
            localparam key_entry_t ENTRY = tracked_key(3'(gi));
            assign match[gi] = (code == ENTRY.code) && (ext == ENTRY.ext);
        end
    endgenerate

    // Table entries are unique, so at most one bit of match is ever set.
    always_comb begin
        hit   = |match;
        index = 3'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (match[i]) begin
                index = 3'(i);
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns the byte stream from a PS/2 frame receiver into make/break key events,
// tracks a held-key bitmap for eight game keys and counts dropped input.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic [7:0] key_held,
    output logic [7:0] last_make,
    output logic [7:0] drop_count
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg;
    logic [2:0]       skip_cnt_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;

    logic byte_ok;
    logic ev_fire;
    logic ev_ext;
    logic ev_break;
    logic ev_pause;
    logic map_hit;
    logic [2:0] map_index;

    assign byte_ok = rx_valid && !rx_err;

    // Decide whether the current byte completes an event, and of what kind.
    always_comb begin
        ev_ext   = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
        ev_break = (state_reg == ST_BRK) || (state_reg == ST_EXT_BRK);
        ev_pause = byte_ok && (state_reg == ST_SKIP) && (skip_cnt_reg == 3'd1);
        ev_fire  = 1'b0;
        if (byte_ok) begin
            case (state_reg)
                ST_IDLE:    ev_fire = (rx_data != CODE_EXT) && (rx_data != CODE_BRK) &&
                                      (rx_data != CODE_PAUSE) && !is_ignored(rx_data);
                ST_EXT:     ev_fire = (rx_data != CODE_BRK);
                ST_BRK,
                ST_EXT_BRK: ev_fire = 1'b1;
                ST_SKIP:    ev_fire = ev_pause;
                default:    ev_fire = 1'b0;
            endcase
        end
    end

    ps2_key_map u_key_map (
        .code  (rx_data),
        .ext   (ev_ext),
        .hit   (map_hit),
        .index (map_index)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            skip_cnt_reg <= 3'd0;
            tmo_cnt_reg  <= '0;
            key_code     <= 8'h00;
            key_ext      <= 1'b0;
            key_break    <= 1'b0;
            key_valid    <= 1'b0;
            key_held     <= 8'h00;
            last_make    <= 8'h00;
            drop_count   <= 8'h00;
        end else begin
            key_valid <= 1'b0;
            if (rx_err) begin
                state_reg    <= ST_IDLE;
                skip_cnt_reg <= 3'd0;
                tmo_cnt_reg  <= '0;
                drop_count   <= sat_inc(drop_count);
            end else if (rx_valid) begin
                tmo_cnt_reg <= '0;
                case (state_reg)
                    ST_IDLE: begin
                        if (rx_data == CODE_EXT) begin
                            state_reg <= ST_EXT;
                        end else if (rx_data == CODE_BRK) begin
                            state_reg <= ST_BRK;
                        end else if (rx_data == CODE_PAUSE) begin
                            state_reg    <= ST_SKIP;
                            skip_cnt_reg <= PAUSE_TAIL;
                        end
                    end
                    ST_EXT: begin
                        state_reg <= (rx_data == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    ST_SKIP: begin
                        skip_cnt_reg <= skip_cnt_reg - 3'd1;
                        if (skip_cnt_reg == 3'd1) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase

                if (ev_fire) begin
                    key_valid <= 1'b1;
                    key_code  <= ev_pause ? CODE_PAUSE : rx_data;
                    key_ext   <= ev_ext;
                    key_break <= ev_break;
                    if (!ev_break) begin
                        last_make <= ev_pause ? CODE_PAUSE : rx_data;
                    end
                    // The pause event reports E1, not the byte that closed it.
                    if (map_hit && !ev_pause) begin
                        key_held[map_index] <= !ev_break;
                    end
                end
            end else if (state_reg != ST_IDLE) begin
                if (tmo_cnt_reg == TMO_LAST) begin
                    state_reg    <= ST_IDLE;
                    skip_cnt_reg <= 3'd0;
                    tmo_cnt_reg  <= '0;
                    drop_count   <= sat_inc(drop_count);
                end else begin
                    tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: a sequence-level model predicts
// events into a queue that a negedge monitor drains against the DUT.
module tb_ps2_scancode_decoder;

    localparam int TMO = 40;

    logic       clock50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic [7:0] key_held;
    logic [7:0] last_make;
    logic [7:0] drop_count;

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50   (clock50),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_break  (key_break),
        .key_valid  (key_valid),
        .key_held   (key_held),
        .last_make  (last_make),
        .drop_count (drop_count)
    );

    always #5 clock50 = ~clock50;

    int cyc = 0;
    always @(posedge clock50) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] held;
        logic [7:0] last;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;

    // Reference model: the bytes of the sequence in progress, plus key state.
    logic [7:0] pend[$];
    logic [7:0] m_held = 8'h00;
    logic [7:0] m_last = 8'h00;
    logic [7:0] m_drop = 8'h00;
    logic [7:0] key_codes[8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] key_ext_mask = 8'hF0;
    logic [7:0] ignore_set[5] = '{8'hFA, 8'hAA, 8'hEE, 8'h00, 8'hFF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic int key_slot(input logic [7:0] c, input logic e);
        for (int i = 0; i < 8; i++) begin
            if (key_codes[i] == c && key_ext_mask[i] == e) return i;
        end
        return -1;
    endfunction

    function automatic logic ignorable(input logic [7:0] c);
        for (int i = 0; i < 5; i++) begin
            if (ignore_set[i] == c) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push_event(input logic [7:0] c, input logic e, input logic b);
        exp_t x;
        x.code = c;
        x.ext  = e;
        x.brk  = b;
        x.held = m_held;
        x.last = m_last;
        x.cyc  = cyc;
        exp_q.push_back(x);
    endtask

    task automatic model_drop();
        pend.delete();
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic v, input logic e);
        logic ext;
        logic brk;
        int   slot;
        if (e) begin
            model_drop();
            return;
        end
        if (!v) return;
        pend.push_back(b);
        if (pend[0] == 8'hE1) begin
            if (pend.size() == 8) begin
                m_last = 8'hE1;
                push_event(8'hE1, 1'b0, 1'b0);
                pend.delete();
            end
            return;
        end
        if (pend.size() == 1 && ignorable(b)) begin
            pend.delete();
            return;
        end
        if (pend.size() == 1 && (b == 8'hE0 || b == 8'hF0)) return;
        if (pend.size() == 2 && pend[0] == 8'hE0 && b == 8'hF0) return;
        ext = (pend[0] == 8'hE0);
        brk = (pend.size() >= 2) && (pend[pend.size()-2] == 8'hF0);
        slot = key_slot(b, ext);
        if (slot >= 0) m_held[slot] = !brk;
        if (!brk) m_last = b;
        push_event(b, ext, brk);
        pend.delete();
    endtask

    task automatic model_reset();
        pend.delete();
        m_held = 8'h00;
        m_last = 8'h00;
        m_drop = 8'h00;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock50);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic v = 1'b1, input logic e = 1'b0);
        rx_data  = b;
        rx_valid = v;
        rx_err   = e;
        model_byte(b, v, e);
        tick(1);
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic rsend(input logic [7:0] b, input logic v = 1'b1, input logic e = 1'b0);
        send(b, v, e);
        tick($urandom_range(0, 2));
    endtask

    task automatic rand_seq();
        int kind;
        int i;
        kind = $urandom_range(0, 9);
        case (kind)
            3, 4: begin
                if ($urandom_range(0, 1) == 1) rsend(8'hE0);
                if ($urandom_range(0, 1) == 1) rsend(8'hF0);
                rsend(8'($urandom_range(0, 255)));
            end
            5: begin
                rsend(8'hE1);
                repeat (7) rsend(8'($urandom_range(0, 255)));
            end
            6: rsend(ignore_set[$urandom_range(0, 4)]);
            7: rsend(8'($urandom_range(0, 255)));
            8: rsend(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
            default: begin
                i = $urandom_range(0, 7);
                if (key_ext_mask[i]) rsend(8'hE0);
                if ($urandom_range(0, 1) == 1) rsend(8'hF0);
                rsend(key_codes[i]);
            end
        endcase
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_key_code"}, 32'(key_code), 32'h0);
        chk({tag, "_key_ext"}, 32'(key_ext), 32'h0);
        chk({tag, "_key_break"}, 32'(key_break), 32'h0);
        chk({tag, "_key_valid"}, 32'(key_valid), 32'h0);
        chk({tag, "_key_held"}, 32'(key_held), 32'h0);
        chk({tag, "_last_make"}, 32'(last_make), 32'h0);
        chk({tag, "_drop_count"}, 32'(drop_count), 32'h0);
    endtask

    // Monitor: every key_valid pulse must match the oldest predicted event.
    always @(negedge clock50) begin
        if (key_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got code %0h ext %0b brk %0b, required no event",
                         key_code, key_ext, key_break);
            end else begin
                mon_e = exp_q.pop_front();
                chk("evt_code", 32'(key_code), 32'(mon_e.code));
                chk("evt_ext", 32'(key_ext), 32'(mon_e.ext));
                chk("evt_break", 32'(key_break), 32'(mon_e.brk));
                chk("evt_held", 32'(key_held), 32'(mon_e.held));
                chk("evt_last_make", 32'(last_make), 32'(mon_e.last));
                chk("evt_latency", 32'(cyc), 32'(mon_e.cyc + 1));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk_all_zero("reset");
        reset = 1'b0;
        tick(2);

        // W make then break
        send(8'h1D);
        send(8'hF0);
        send(8'h1D);
        tick(3);
        chk("w_held", 32'(key_held), 32'(m_held));
        chk("w_last_make", 32'(last_make), 32'h1D);

        // Up arrow make/break, then non-extended 75 (keypad 8)
        send(8'hE0);
        send(8'h75);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        send(8'h75);
        tick(3);
        chk("up_held", 32'(key_held), 32'h0);

        // Pause sequence: one E1 event after the eighth byte
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        tick(3);
        chk("pause_last_make", 32'(last_make), 32'hE1);
        chk("pause_pending", 32'(exp_q.size()), 32'h0);

        // Abandoned E0 prefix times out
        send(8'hE0);
        tick(TMO + 5);
        model_drop();
        chk("timeout_drop", 32'(drop_count), 32'(m_drop));
        send(8'h1C);
        tick(3);

        // Errored F0 is discarded, following 23 decodes as a make
        send(8'hF0, 1'b1, 1'b1);
        send(8'h23);
        tick(3);
        chk("err_drop", 32'(drop_count), 32'(m_drop));
        chk("err_held_d", 32'(key_held[3]), 32'h1);

        // Reset in the middle of E0 F0 with WASD held
        send(8'h1D);
        send(8'h1B);
        tick(3);
        chk("wasd_held", 32'(key_held), 32'h0F);
        send(8'hE0);
        send(8'hF0);
        chk("pre_reset_pending", 32'(exp_q.size()), 32'h0);
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        model_reset();
        tick(2);
        reset = 1'b0;
        tick(1);
        send(8'h1B);
        tick(3);
        chk("post_reset_held", 32'(key_held), 32'h04);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            rand_seq();
            if (n % 50 == 49) begin
                tick(2);
                chk("rand_drop", 32'(drop_count), 32'(m_drop));
                chk("rand_held", 32'(key_held), 32'(m_held));
            end
        end

        // Drop counter saturation
        tick(3);
        repeat (300) send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
        tick(2);
        chk("drop_saturate", 32'(drop_count), 32'(m_drop));
        chk("drop_saturate_ff", 32'(drop_count), 32'hFF);

        tick(3);
        chk("final_pending", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
